perm_engine: RTL and testbench
==============================

// Module: perm_engine
// PURPOSE
//   Parametrised, runtime-programmable bit-permutation engine for the cipher datapath.
//   Generalises the fixed 8-bit S-DES initial permutation: the default map is the S-DES IP.
//   Width is a parameter. The map can be reloaded at runtime with a sequential bijection check.
//   One registered valid/ready stage sits between the key-schedule/round logic and the blocks around it.
// PARAMETERS
//   WIDTH       8                         data width in bits; 2..64
//   IDX_W       $clog2(WIDTH)             width of one map entry
//   DEFAULT_MAP {3'd1,3'd5,3'd2,3'd0,     WIDTH*IDX_W packed map; entry i at bits [i*IDX_W +: IDX_W], MSB-first
//                3'd3,3'd7,3'd4,3'd6}     the reset map; must be a bijection
// PORTS
//   clk        in   1          single clock, rising edge
//   rst_n      in   1          synchronous reset, active-low
//   in_valid   in   1          input word offered
//   in_ready   out  1          engine accepts the word this cycle
//   in_data    in   [0:WIDTH-1] word; bit 0 = leftmost
//   in_inv     in   1          1 = apply the inverse permutation (needs PERM_INV_EN)
//   out_valid  out  1          output word held
//   out_ready  in   1          consumer accepts the word
//   out_data   out  [0:WIDTH-1] permuted word
//   cfg_we     in   1          write shadow map entry
//   cfg_idx    in   IDX_W      shadow entry to write (destination bit index)
//   cfg_src    in   IDX_W      source bit index stored in that entry
//   cfg_commit in   1          start the check; on success, copy shadow to active
//   cfg_busy   out  1          check in progress
//   cfg_err    out  1          last commit rejected (map not a bijection); sticky
// BEHAVIOUR
//   - Interface: one clock; reset is synchronous and active-low.
//   - Reset values:
//     - out_valid=0, out_data=0, cfg_busy=0, cfg_err=0.
//     - Active and shadow maps = DEFAULT_MAP; FSM = IDLE.
//   - Forward: out_data[i] = in_data[map[i]].
//   - Inverse: out_data[map[i]] = in_data[i].
//   - Handshake:
//     - Transfer when in_valid & in_ready.
//     - in_ready = !out_valid | out_ready, combinational.
//     - Latency is 1 cycle. Full throughput of 1 word/clk.
//     - While out_valid=1 and out_ready=0, out_data is held stable.
//   - Map used: the active map sampled in the cycle of acceptance.
//   - The datapath never stalls for configuration.
//   - cfg_we in IDLE: shadow[cfg_idx] <= cfg_src.
//     - cfg_idx >= WIDTH: write ignored.
//     - In CHECK: write ignored.
//   - FSM IDLE -> CHECK on cfg_commit:
//     - Entry clears cfg_err and the seen mask. cfg_busy=1.
//     - cfg_we with cfg_commit in the same cycle: the write lands first, then the check covers it.
//   - CHECK: one entry per cycle, k = 0..WIDTH-1. Sets seen[shadow[k]].
//     - A duplicate or out-of-range src sets a fail flag.
//     - cfg_commit during CHECK is ignored.
//   - CHECK end, after WIDTH cycles, -> IDLE with cfg_busy=0:
//     - Pass: active <= shadow. Words accepted from the next cycle use the new map.
//     - Fail: cfg_err=1 and the active map is unchanged.
//   - Reset mid-CHECK: the check is aborted.
//     - Both maps return to DEFAULT_MAP. A word in flight is dropped (out_valid=0).
// CONFIGURATION
//   PERM_INV_EN defined:
//     - in_inv selects inverse per word. It is sampled with the word and pipelined alongside it.
//   PERM_INV_EN undefined:
//     - in_inv is ignored and the engine is forward only. The port remains for interface stability.
// TESTING
//   1. Reset, default map, in_data=8'hA0 -> out_data=8'h30, one cycle later.
//   2. PERM_INV_EN, in_inv=1, in_data=8'h30 -> 8'hA0.
//      - Back-to-back fwd/inv words alternate correctly.
//   3. Write identity map (idx i <- src i), then commit:
//      - cfg_busy high for 8 cycles, cfg_err=0.
//      - Then 8'h5A -> 8'h5A.
//   4. Write shadow[3]=shadow[0]=1, then commit:
//      - cfg_err=1 after 8 cycles.
//      - 8'hA0 -> 8'h30 (old map retained).
//   5. Hold out_ready=0 with a word pending:
//      - in_ready=0 and out_data stable for 5 cycles.
//      - Release: 1 word/cycle streaming, no loss or duplication.
//   6. Pull rst_n low on cycle 3 of a CHECK:
//      - cfg_busy=0, out_valid=0.
//      - Then 8'hA0 -> 8'h30.

Source files
------------

// File: rtl/perm_engine.sv
// perm_engine: runtime-programmable bit-permutation engine with one registered
// valid/ready stage. The reset map is DEFAULT_MAP (the S-DES initial permutation
// by default). A shadow map is loaded entry by entry and copied to the active map
// only after a sequential bijection check passes.
// Optional feature macro: PERM_INV_EN. When it is defined, in_inv selects the
// inverse permutation for each word. When it is undefined, the engine is
// forward-only and in_inv is ignored.
module perm_engine #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter logic [0:WIDTH*IDX_W-1] DEFAULT_MAP = {3'd1, 3'd5, 3'd2, 3'd0,
                                                   3'd3, 3'd7, 3'd4, 3'd6}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [IDX_W-1:0] cfg_src,
  input  logic             cfg_commit,
  output logic             cfg_busy,
  output logic             cfg_err
);

  // Indices are zero-extended by one bit so that an in-range test also works
  // when WIDTH is not a power of two.
  localparam logic [IDX_W:0]   WIDTH_C = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_CHECK} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] seen_q, seen_d;
  logic             fail_q, fail_d;
  logic             err_q, err_d;
  logic             shadow_we;
  logic             active_load;

  logic [IDX_W-1:0] active_q [WIDTH];
  logic [IDX_W-1:0] shadow_q [WIDTH];

  logic             out_valid_q;
  logic [0:WIDTH-1] out_data_q;
  logic [0:WIDTH-1] perm_fwd;
  logic [0:WIDTH-1] perm_sel;
  logic             accept;

  // Configuration FSM state and check bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      seen_q  <= '0;
      fail_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      seen_q  <= seen_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. A commit clears the error flag and the seen mask. The
  // check then walks one shadow entry per cycle and marks each source bit.
  always_comb begin
    logic [IDX_W-1:0] src;
    logic             src_ok;
    logic             fail_now;
    state_d     = state_q;
    k_d         = k_q;
    seen_d      = seen_q;
    fail_d      = fail_q;
    err_d       = err_q;
    shadow_we   = 1'b0;
    active_load = 1'b0;
    src         = shadow_q[k_q];
    src_ok      = ({1'b0, src} < WIDTH_C);
    fail_now    = fail_q;
    case (state_q)
      ST_IDLE: begin
        // A write in the same cycle as a commit lands before the check reads it.
        shadow_we = cfg_we && ({1'b0, cfg_idx} < WIDTH_C);
        if (cfg_commit) begin
          state_d = ST_CHECK;
          k_d     = '0;
          seen_d  = '0;
          fail_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_CHECK: begin
        if (!src_ok) begin
          fail_now = 1'b1;
        end else begin
          if (seen_q[src]) fail_now = 1'b1;
          seen_d[src] = 1'b1;
        end
        fail_d = fail_now;
        k_d    = k_q + IDX_W'(1);
        if (k_q == K_LAST) begin
          state_d = ST_IDLE;
          if (fail_now) err_d = 1'b1;
          else          active_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Map storage. Both maps reload the default on reset. The active map changes
  // only when a check passes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        shadow_q[i] <= DEFAULT_MAP[i*IDX_W +: IDX_W];
        active_q[i] <= DEFAULT_MAP[i*IDX_W +: IDX_W];
      end
    end else begin
      if (shadow_we) shadow_q[cfg_idx] <= cfg_src;
      if (active_load) begin
        for (int i = 0; i < WIDTH; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Forward permutation through the active map: out[i] = in[map[i]].
  always_comb begin
    perm_fwd = '0;
    for (int i = 0; i < WIDTH; i++) perm_fwd[i] = in_data[active_q[i]];
  end

`ifdef PERM_INV_EN
  logic [0:WIDTH-1] perm_inv;

  // Inverse permutation: out[map[i]] = in[i]. in_inv is applied at the moment
  // of acceptance, so it travels with its word through the output register.
  always_comb begin
    perm_inv = '0;
    for (int i = 0; i < WIDTH; i++) perm_inv[active_q[i]] = in_data[i];
    perm_sel = in_inv ? perm_inv : perm_fwd;
  end
`else
  logic unused_inv;
  assign unused_inv = in_inv;

  // Forward-only build: in_inv has no effect.
  always_comb begin
    perm_sel = perm_fwd;
  end
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register. It loads on acceptance and holds its word while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= perm_sel;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_busy  = (state_q == ST_CHECK);
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_perm_engine.sv
// tb_perm_engine: directed-vector bench for perm_engine (WIDTH=8, default S-DES map).
// A driver pushes hand-computed expected words into a queue. A monitor pops them
// and compares whenever the DUT hands over an output word.
module tb_perm_engine;

`ifdef PERM_INV_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [0:7] in_data = '0;
  logic       in_inv = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [0:7] out_data;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [2:0] cfg_src = '0;
  logic       cfg_commit = 1'b0;
  logic       cfg_busy;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic [7:0] exp_q[$];

  perm_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src(cfg_src),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge when out_valid and out_ready are both high.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%02h want no word", out_data);
        end else begin
          e = exp_q.pop_front();
          popped++;
          $display("OUT #%0d data=0x%02h exp=0x%02h", popped, out_data, e);
          check("out_data", {24'h0, out_data}, {24'h0, e});
        end
      end
    end
  end

  // Offer one word, wait until it is accepted, and record the expected result.
  task automatic send(input logic [7:0] d, input logic inv, input logic [7:0] e, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        pushed++;
        $display("IN  data=0x%02h inv=%0b exp=0x%02h", d, inv, e);
        break;
      end
      waits++;
      if (waits > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 want 1");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [2:0] src);
    cfg_we = 1'b1; cfg_idx = idx; cfg_src = src;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (cfg_busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int w;
    int n;
    int busy_seen;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_cfg_busy", {31'h0, cfg_busy}, 32'h0);
    check("rst_cfg_err", {31'h0, cfg_err}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // 1: default map, A0 -> 30 with one-cycle latency
    out_ready = 1'b1;
    send(8'hA0, 1'b0, 8'h30, w);
    check("t1_latency_valid", {31'h0, out_valid}, 32'h1);
    check("t1_latency_data", {24'h0, out_data}, 32'h30);
    idle(2);

    // 2: alternating forward/inverse words (inverse ignored in forward-only build)
    send(8'h30, 1'b1, INV_ON ? 8'hA0 : 8'h28, w);
    send(8'hA0, 1'b0, 8'h30, w);
    send(8'h5A, 1'b1, INV_ON ? 8'h9C : 8'h8B, w);
    send(8'h9C, 1'b0, 8'h5A, w);
    send(8'h01, 1'b1, INV_ON ? 8'h02 : 8'h04, w);
    idle(3);

    // 3: identity map commit
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 3'(i));
    commit();
    busy_len(n);
    check("t3_busy_cycles", n, 8);
    check("t3_cfg_err", {31'h0, cfg_err}, 32'h0);
    send(8'h5A, 1'b0, 8'h5A, w);
    send(8'hC3, 1'b0, 8'hC3, w);
    idle(2);

    // 4: duplicate source rejected, old (default) map retained
    do_reset();
    cfg_write(3'd3, 3'd1);
    cfg_write(3'd0, 3'd1);
    commit();
    busy_len(n);
    check("t4_busy_cycles", n, 8);
    check("t4_cfg_err", {31'h0, cfg_err}, 32'h1);
    send(8'hA0, 1'b0, 8'h30, w);
    idle(2);

    // 4b: write together with commit lands first; error clears on entry and stays clear
    cfg_we = 1'b1; cfg_idx = 3'd3; cfg_src = 3'd0;
    commit();
    cfg_we = 1'b0;
    check("t4b_err_cleared", {31'h0, cfg_err}, 32'h0);
    busy_len(n);
    check("t4b_busy_cycles", n, 8);
    check("t4b_cfg_err", {31'h0, cfg_err}, 32'h0);
    send(8'hA0, 1'b0, 8'h30, w);
    idle(2);

    // 5: backpressure holds data stable, then full-rate streaming
    out_ready = 1'b0;
    send(8'h5A, 1'b0, 8'h8B, w);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_inv   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t5_in_ready_low", {31'h0, in_ready}, 32'h0);
      check("t5_out_valid", {31'h0, out_valid}, 32'h1);
      check("t5_out_data_hold", {24'h0, out_data}, 32'h8B);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'hFF, 1'b0, 8'hFF, w);
    check("t5_stream_wait0", w, 0);
    send(8'h01, 1'b0, 8'h04, w);
    check("t5_stream_wait1", w, 0);
    send(8'hA0, 1'b0, 8'h30, w);
    check("t5_stream_wait2", w, 0);
    send(8'h30, 1'b0, 8'h28, w);
    check("t5_stream_wait3", w, 0);
    idle(3);
    check("t5_all_drained", popped, pushed);

    // 6: reset during CHECK aborts it and drops the in-flight word
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 3'(i));
    out_ready = 1'b0;
    send(8'hA0, 1'b0, 8'h30, w);
    in_valid = 1'b0;
    commit();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_busy_before", {31'h0, cfg_busy}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_busy_after", {31'h0, cfg_busy}, 32'h0);
    check("t6_valid_after", {31'h0, out_valid}, 32'h0);
    pushed -= exp_q.size();
    exp_q.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    busy_seen = 0;
    send(8'hA0, 1'b0, 8'h30, w);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (cfg_busy) busy_seen++;
    end
    check("t6_no_resume", busy_seen, 0);
    send(8'h5A, 1'b0, 8'h8B, w);
    idle(3);

    check("final_drained", popped, pushed);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
